// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types and constants for the serial TX arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_ARB       = 3'd0,
        ST_POLL      = 3'd1,
        ST_POLL_WAIT = 3'd2,
        ST_WRITE     = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    localparam logic [3:0] UART_STATUS_ADDR = 4'd8;
    localparam logic [3:0] UART_DATA_ADDR   = 4'd9;
    localparam int         STAT_TX_BUSY     = 1;

    // Largest of the three phase lengths, used to size the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or above ptr (mod NREQ) that is both requesting and unmasked.
// Latency: purely combinational.
// Backpressure: none; vld low means nothing eligible this cycle.
module rr_arbiter
    import serial_tx_arbiter_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            vld
);

    logic [IW-1:0] pos;

    // Scan upward from the pointer, wrapping at NREQ, and keep the first hit.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'((int'(ptr) + k) % NREQ);
            if (!vld && req[pos] && mask[pos]) begin
                vld      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares the serial port transmitter between NREQ byte sources: poll TX busy, then write the granted byte.
// Latency: with TX idle, grant edge -> POLL cycle 1, write cycles 2..1+WR_HOLD, back in ARB after REL_GAP more.
// Backpressure: a requester holds valid/data until its one-cycle req_ready pulse; busy TX stalls in POLL/POLL_WAIT.
module serial_tx_arbiter
    import serial_tx_arbiter_pkg::*;
#(
    parameter int  NREQ     = 4,
    parameter int  WR_HOLD  = 2,
    parameter int  REL_GAP  = 2,
    parameter int  POLL_GAP = 8,
    localparam int IW       = $clog2(NREQ)
) (
    input  logic              cpuclk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_ready,
    output logic [IW-1:0]     grant_id,
    output logic              busy,
    output logic              uart_ncs,
    output logic              uart_nrd,
    output logic              uart_nwr,
    output logic [3:0]        uart_addr,
    output logic [7:0]        uart_wdata,
    input  logic [7:0]        uart_rdata
);

    localparam int CNT_MAX = max3(WR_HOLD, REL_GAP, POLL_GAP);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            cnt_done;

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   arb_ptr;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] arb_mask;
    logic [NREQ-1:0] arb_gnt;
    logic            arb_vld;
    logic [NREQ-1:0] lock_sel;
    logic            lock_hold;
    logic            lock_active;
    logic            grant_fire;
    logic [7:0]      byte_q;
    logic [7:0]      req_bytes [NREQ];

    logic            ncs_n;
    logic            nrd_n;
    logic            nwr_n;
    logic [3:0]      addr_n;
    logic [7:0]      wdata_n;
    logic [NREQ-1:0] ready_n;
    logic            busy_n;

    // Only the TX-busy status bit matters; the rest of the status byte is ignored.
    logic            unused_rdata;
    assign unused_rdata = ^{uart_rdata[7:STAT_TX_BUSY+1], uart_rdata[STAT_TX_BUSY-1:0]};

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // While a lock is held and still asserted, only the locked requester is eligible.
    always_comb begin
        lock_sel           = '0;
        lock_sel[grant_id] = 1'b1;
        lock_active        = lock_hold & req_lock[grant_id];
        arb_mask           = lock_active ? lock_sel : '1;
        arb_ptr            = lock_active ? grant_id : rr_ptr;
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req  (req_valid),
        .ptr  (arb_ptr),
        .mask (arb_mask),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .vld  (arb_vld)
    );

    assign grant_fire = (state == ST_ARB) && arb_vld;

    // Phase counter reaches the last cycle of the current timed state.
    always_comb begin
        case (state)
            ST_POLL_WAIT: cnt_done = (cnt == CW'(POLL_GAP - 1));
            ST_WRITE:     cnt_done = (cnt == CW'(WR_HOLD - 1));
            ST_RELEASE:   cnt_done = (cnt == CW'(REL_GAP - 1));
            default:      cnt_done = 1'b0;
        endcase
    end

    // State register; the phase counter restarts on every state change.
    always_ff @(posedge cpuclk or posedge rst) begin
        if (rst) begin
            state <= ST_ARB;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + CW'(1);
        end
    end

    // Next-state decode: grant, one status poll, optional wait, write, release.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:       if (arb_vld) state_nxt = ST_POLL;
            ST_POLL:      state_nxt = uart_rdata[STAT_TX_BUSY] ? ST_POLL_WAIT : ST_WRITE;
            ST_POLL_WAIT: if (cnt_done) state_nxt = ST_POLL;
            ST_WRITE:     if (cnt_done) state_nxt = ST_RELEASE;
            ST_RELEASE:   if (cnt_done) state_nxt = ST_ARB;
            default:      state_nxt = ST_ARB;
        endcase
    end

    // Grant bookkeeping: latch the byte, remember the winner, advance the pointer unless locked.
    always_ff @(posedge cpuclk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            byte_q    <= '0;
            lock_hold <= 1'b0;
        end else begin
            if (grant_fire) begin
                byte_q   <= req_bytes[arb_idx];
                grant_id <= arb_idx;
                if (!lock_active) begin
                    rr_ptr <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                end
            end
            if (state == ST_RELEASE && cnt_done) begin
                lock_hold <= req_lock[grant_id];
            end else if (state == ST_ARB && lock_hold && !req_lock[grant_id]) begin
                lock_hold <= 1'b0;
            end
        end
    end

    // Output decode from the upcoming state so every pin comes straight off a flop.
    always_comb begin
        ncs_n   = 1'b1;
        nrd_n   = 1'b1;
        nwr_n   = 1'b1;
        addr_n  = UART_STATUS_ADDR;
        wdata_n = uart_wdata;
        ready_n = grant_fire ? arb_gnt : '0;
        busy_n  = (state_nxt != ST_ARB);
        case (state_nxt)
            ST_POLL: begin
                ncs_n = 1'b0;
                nrd_n = 1'b0;
            end
            ST_WRITE: begin
                ncs_n   = 1'b0;
                nwr_n   = 1'b0;
                addr_n  = UART_DATA_ADDR;
                wdata_n = byte_q;
            end
            default: ;
        endcase
    end

    // Output registers; reset releases every strobe at once.
    always_ff @(posedge cpuclk or posedge rst) begin
        if (rst) begin
            uart_ncs   <= 1'b1;
            uart_nrd   <= 1'b1;
            uart_nwr   <= 1'b1;
            uart_addr  <= UART_STATUS_ADDR;
            uart_wdata <= '0;
            req_ready  <= '0;
            busy       <= 1'b0;
        end else begin
            uart_ncs   <= ncs_n;
            uart_nrd   <= nrd_n;
            uart_nwr   <= nwr_n;
            uart_addr  <= addr_n;
            uart_wdata <= wdata_n;
            req_ready  <= ready_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: per-requester byte sources, a status-register model and a write scoreboard.
// Latency: checks the idle-TX grant/poll/write/release timeline and busy-poll spacing.
// Backpressure: requesters hold valid until their req_ready pulse; TX busy is driven per poll count.
module tb_serial_tx_arbiter;

    logic        cpuclk = 1'b0;
    logic        rst    = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_lock  = '0;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        uart_ncs;
    logic        uart_nrd;
    logic        uart_nwr;
    logic [3:0]  uart_addr;
    logic [7:0]  uart_wdata;
    logic [7:0]  uart_rdata = '0;

    always #125 cpuclk = ~cpuclk;

    serial_tx_arbiter #(
        .NREQ     (4),
        .WR_HOLD  (2),
        .REL_GAP  (2),
        .POLL_GAP (8)
    ) dut (
        .cpuclk     (cpuclk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .uart_ncs   (uart_ncs),
        .uart_nrd   (uart_nrd),
        .uart_nwr   (uart_nwr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         strobe_bad = 0;
    int         cyc = 0;

    logic [7:0] src_mem [4][8];
    int         src_head [4];
    int         src_tail [4];
    logic [3:0] lock_en;
    int         poll_cnt;
    int         busy_polls;
    int         poll_cyc [16];
    int         poll_addr_bad;
    logic       prev_nwr;
    int         exp_q [$];
    int         obs_q [$];
    int         wr_cyc [$];

    // Strobe sanity on every cycle of every test.
    always @(negedge cpuclk) begin
        if ((uart_nrd | uart_nwr) !== 1'b1) strobe_bad++;
        if (uart_nrd && uart_nwr && uart_ncs !== 1'b1) strobe_bad++;
    end

    function automatic bit srcs_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < 4; i++) if (src_head[i] < src_tail[i]) e = 1'b0;
        return e;
    endfunction

    function automatic int wr_word(input int id, input int d);
        return (9 << 16) | (id << 8) | d;
    endfunction

    // Advance to the next falling edge, record DUT activity, then drive sources and status model.
    task automatic step();
        @(negedge cpuclk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i] && src_head[i] < src_tail[i]) src_head[i]++;
        end
        if (!uart_ncs && !uart_nrd) begin
            if (poll_cnt < 16) poll_cyc[poll_cnt] = cyc;
            if (uart_addr !== 4'd8) poll_addr_bad++;
            poll_cnt++;
        end
        if (!uart_nwr && prev_nwr) begin
            obs_q.push_back((int'(uart_addr) << 16) | (int'(grant_id) << 8) | int'(uart_wdata));
            wr_cyc.push_back(cyc);
        end
        prev_nwr = uart_nwr;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]      = (src_head[i] < src_tail[i]);
            req_data[8*i +: 8] = (src_head[i] < src_tail[i]) ? src_mem[i][src_head[i]] : 8'h00;
            req_lock[i]       = lock_en[i] && (src_head[i] < src_tail[i]);
        end
        uart_rdata = {6'b0, (poll_cnt <= busy_polls), 1'b0};
    endtask

    task automatic clear_tb();
        for (int i = 0; i < 4; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        lock_en       = '0;
        poll_cnt      = 0;
        busy_polls    = 0;
        poll_addr_bad = 0;
        prev_nwr      = 1'b1;
        exp_q.delete();
        obs_q.delete();
        wr_cyc.delete();
    endtask

    task automatic push_src(input int i, input logic [7:0] b);
        src_mem[i][src_tail[i]] = b;
        src_tail[i]++;
    endtask

    task automatic do_reset();
        clear_tb();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic run_until_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (obs_q.size() >= exp_q.size() && !busy && srcs_empty()) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_tb();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if ({uart_ncs, uart_nrd, uart_nwr} !== 3'b111) begin n_bad++; $display("FAIL rst_strobes: got %b want 111", {uart_ncs, uart_nrd, uart_nwr}); end
        n_cmp++; if (uart_addr !== 4'd8) begin n_bad++; $display("FAIL rst_addr: got %0d want 8", uart_addr); end
        n_cmp++; if (uart_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_wdata: got %h want 00", uart_wdata); end
        n_cmp++; if ({req_ready, grant_id, busy} !== 7'b0) begin n_bad++; $display("FAIL rst_ctl: got %b want 0000000", {req_ready, grant_id, busy}); end
        rst = 1'b0;
        step();
        n_cmp++; if ({uart_ncs, uart_nrd, uart_nwr} !== 3'b111) begin n_bad++; $display("FAIL post_rst_strobes: got %b want 111", {uart_ncs, uart_nrd, uart_nwr}); end
        n_cmp++; if (uart_addr !== 4'd8) begin n_bad++; $display("FAIL post_rst_addr: got %0d want 8", uart_addr); end
        n_cmp++; if ({req_ready, grant_id, busy} !== 7'b0) begin n_bad++; $display("FAIL post_rst_ctl: got %b want 0000000", {req_ready, grant_id, busy}); end
    endtask

    task automatic test_single_byte();
        int c0, d, rdy_at, rdy_cycles, nwr_first, nwr_cnt, busy_low;
        int e, o;
        do_reset();
        push_src(0, 8'h41);
        exp_q.push_back(wr_word(0, 8'h41));
        step();
        c0 = cyc;
        rdy_at = -1; rdy_cycles = 0; nwr_first = -1; nwr_cnt = 0; busy_low = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            d = cyc - c0;
            if (req_ready !== 4'b0) rdy_cycles++;
            if (req_ready[0] && rdy_at < 0) rdy_at = d;
            if (!uart_nwr) begin
                nwr_cnt++;
                if (nwr_first < 0) nwr_first = d;
            end
            if (!busy && busy_low < 0) busy_low = d;
        end
        n_cmp++; if (rdy_at !== 1) begin n_bad++; $display("FAIL single_ready_cycle: got %0d want 1", rdy_at); end
        n_cmp++; if (rdy_cycles !== 1) begin n_bad++; $display("FAIL single_ready_width: got %0d want 1", rdy_cycles); end
        n_cmp++; if (poll_cnt !== 1) begin n_bad++; $display("FAIL single_polls: got %0d want 1", poll_cnt); end
        n_cmp++; if (poll_cyc[0] - c0 !== 1) begin n_bad++; $display("FAIL single_poll_cycle: got %0d want 1", poll_cyc[0] - c0); end
        n_cmp++; if (poll_addr_bad !== 0) begin n_bad++; $display("FAIL single_poll_addr: got %0d bad want 0", poll_addr_bad); end
        n_cmp++; if (nwr_first !== 2) begin n_bad++; $display("FAIL single_nwr_start: got %0d want 2", nwr_first); end
        n_cmp++; if (nwr_cnt !== 2) begin n_bad++; $display("FAIL single_nwr_len: got %0d want 2", nwr_cnt); end
        n_cmp++; if (busy_low !== 6) begin n_bad++; $display("FAIL single_busy_drop: got %0d want 6", busy_low); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL single_write addr/id/data: got %h want %h", o, e); end
        end
    endtask

    task automatic test_round_robin();
        bit to;
        int e, o;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_src(i, 8'((i + 1) * 16));
            push_src(i, 8'((i + 1) * 16));
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) exp_q.push_back(wr_word(i, (i + 1) * 16));
        run_until_idle(300, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rr_timeout: got timeout want idle"); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rr_write addr/id/data: got %h want %h", o, e); end
        end
    endtask

    task automatic test_busy_poll();
        bit to;
        int e, o;
        do_reset();
        busy_polls = 3;
        push_src(1, 8'h5A);
        exp_q.push_back(wr_word(1, 8'h5A));
        run_until_idle(200, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL busy_timeout: got timeout want idle"); end
        n_cmp++; if (poll_cnt !== 4) begin n_bad++; $display("FAIL busy_polls: got %0d want 4", poll_cnt); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (poll_cyc[k+1] - poll_cyc[k] !== 9) begin n_bad++; $display("FAIL busy_gap%0d: got %0d want 9", k, poll_cyc[k+1] - poll_cyc[k]); end
        end
        n_cmp++; if (wr_cyc.size() !== 1) begin n_bad++; $display("FAIL busy_write_count: got %0d want 1", wr_cyc.size()); end
        if (wr_cyc.size() > 0) begin
            n_cmp++; if (wr_cyc[0] !== poll_cyc[3] + 1) begin n_bad++; $display("FAIL busy_write_cycle: got %0d want %0d", wr_cyc[0], poll_cyc[3] + 1); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL busy_write addr/id/data: got %h want %h", o, e); end
        end
    endtask

    task automatic test_lock();
        bit to;
        int e, o;
        do_reset();
        push_src(0, 8'hA0); push_src(0, 8'hA1);
        push_src(1, 8'hB0); push_src(1, 8'hB1);
        push_src(2, 8'hC0); push_src(2, 8'hC1); push_src(2, 8'hC2);
        lock_en[2] = 1'b1;
        exp_q.push_back(wr_word(0, 8'hA0));
        exp_q.push_back(wr_word(1, 8'hB0));
        exp_q.push_back(wr_word(2, 8'hC0));
        exp_q.push_back(wr_word(2, 8'hC1));
        exp_q.push_back(wr_word(2, 8'hC2));
        exp_q.push_back(wr_word(0, 8'hA1));
        exp_q.push_back(wr_word(1, 8'hB1));
        run_until_idle(300, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL lock_timeout: got timeout want idle"); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL lock_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL lock_write addr/id/data: got %h want %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_write();
        bit to, seen;
        int e, o;
        do_reset();
        push_src(2, 8'h77);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            step();
            if (!uart_nwr) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL midrst_no_write: got none want nwr low"); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if ({uart_ncs, uart_nrd, uart_nwr} !== 3'b111) begin n_bad++; $display("FAIL midrst_strobes: got %b want 111", {uart_ncs, uart_nrd, uart_nwr}); end
        step();
        step();
        rst = 1'b0;
        clear_tb();
        step();
        n_cmp++; if ({req_ready, grant_id, busy} !== 7'b0) begin n_bad++; $display("FAIL midrst_ctl: got %b want 0000000", {req_ready, grant_id, busy}); end
        // Requesters 0 and 3 together: a pointer reset to 0 must pick 0 first.
        push_src(0, 8'h01);
        push_src(3, 8'h03);
        exp_q.push_back(wr_word(0, 8'h01));
        exp_q.push_back(wr_word(3, 8'h03));
        run_until_idle(200, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL midrst_timeout: got timeout want idle"); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL midrst_write addr/id/data: got %h want %h", o, e); end
        end
    endtask

    task automatic test_strobes();
        n_cmp++; if (strobe_bad !== 0) begin n_bad++; $display("FAIL strobe_exclusive: got %0d bad cycles want 0", strobe_bad); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_busy_poll();
        test_lock();
        test_reset_mid_write();
        test_strobes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares the serial port transmitter between NREQ on-chip byte sources, for example the CPU console shadow, a debug dumper and a status reporter.
- Drives the serial port's register bus directly: status register at addr 8, TX data register at addr 9.
- Polls the TX-busy bit, then writes each granted byte. Arbitration is round-robin, with an optional per-requester lock for atomic multi-byte packets.

Parameters:
- NREQ, 4, number of requesters (minimum 2).
- WR_HOLD, 2, cycles uart_nwr is held low per data write (minimum 1).
- REL_GAP, 2, cycles with all strobes high after a write, so the serial port clears its write latch and sets TX busy (minimum 2).
- POLL_GAP, 8, idle cycles between consecutive status polls while TX is busy (minimum 1).

Ports:
- cpuclk  in  1  system clock (4 MHz); the only clock.
- rst  in  1  reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  byte for requester i in bits [8i+7:8i].
- req_lock  in  NREQ  holds the grant for a packet.
- req_ready  out  NREQ  one-hot, one-cycle pulse: byte accepted.
- grant_id  out  clog2(NREQ)  index of the last granted requester.
- busy  out  1  high whenever the FSM is not in ARB.
- uart_ncs  out  1  serial port chip select, active low.
- uart_nrd  out  1  read strobe, active low.
- uart_nwr  out  1  write strobe, active low.
- uart_addr  out  4  register address, 8 or 9.
- uart_wdata  out  8  write data.
- uart_rdata  in  8  read data, combinational from the serial port; bit1 = TX busy.

Interface requirement (already decided): one clock; reset is asynchronous and active-high. The clock port is cpuclk and the reset port is rst.

Behaviour:
- All outputs are registered.
- Reset is asynchronous, active-high. During and immediately after reset:
  - uart_ncs, uart_nrd, uart_nwr = 1; uart_addr = 8; uart_wdata = 0.
  - req_ready = 0; grant_id = 0; busy = 0.
  - Round-robin pointer = 0; lock_hold = 0; FSM = ARB.
- Reset mid-operation: strobes deassert immediately; the in-flight byte is dropped and not retried.
- Handshake:
  - A requester holds valid and data stable until it sees its req_ready pulse.
  - The byte is latched internally on the edge that raises ready.
  - Valid may drop without a handshake; that is not an error.
- FSM states: ARB, POLL, POLL_WAIT, WRITE, RELEASE.
- ARB, with no lock_hold:
  - Winner = first i with req_valid[i], scanning from the pointer upward modulo NREQ.
  - On that edge: latch the byte, pulse req_ready[i], set grant_id = i, set pointer = (i+1) mod NREQ, go to POLL.
  - No valid: stay in ARB.
- ARB, with lock_hold: only requester grant_id is eligible.
  - If it is valid: grant it, pointer unchanged.
  - If req_lock[grant_id] drops: clear lock_hold and do a normal round-robin scan in the same cycle.
- POLL (1 cycle): uart_ncs = 0, uart_nrd = 0, uart_addr = 8.
  - Sample uart_rdata[1] on the closing edge.
  - Sample 1: go to POLL_WAIT. Sample 0: go to WRITE.
- POLL_WAIT: strobes high for POLL_GAP cycles, then back to POLL. There is no timeout.
- WRITE: uart_ncs = 0, uart_nwr = 0, uart_addr = 9, uart_wdata = latched byte, for WR_HOLD cycles.
- RELEASE: strobes high and uart_addr = 8 for REL_GAP cycles.
  - On exit, lock_hold = req_lock[grant_id] sampled on that edge; then go to ARB.
- Strobe exclusivity: uart_nrd and uart_nwr are never low in the same cycle. Strobes are never low in ARB, POLL_WAIT or RELEASE.
- Latency from ARB with TX idle:
  - Edge E0: grant; req_ready high for cycle 1; POLL in cycle 1.
  - uart_nwr low in cycles 2 and 3; RELEASE in cycles 4 and 5.
  - ARB again in cycle 6.
- Throughput with TX idle: one byte per 2+WR_HOLD+REL_GAP cycles. In practice the serial line rate dominates.
- Simultaneous events:
  - A lock raised on the same edge as a grant takes effect at the end of RELEASE.
  - req_lock on a non-granted requester is ignored.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - Register address constants: UART_STATUS_ADDR = 8, UART_DATA_ADDR = 9.
  - Status bit index STAT_TX_BUSY = 1.
- One sub-module: rr_arbiter. It takes NREQ, req, pointer and a mask, and produces a one-hot grant plus an index; it is purely combinational. The FSM, pointer update and lock logic stay in serial_tx_arbiter.

Test Plan:
- Single byte: reset, then req_valid = 4'b0001, req_data[7:0] = 8'h41, uart_rdata = 0.
  - req_ready[0] pulses one cycle after valid is sampled.
  - One POLL to addr 8.
  - uart_nwr low for 2 cycles with addr 9 and wdata 8'h41.
  - busy deasserts 6 cycles after the grant.
- Round-robin: all four valid continuously, bytes 8'h10/8'h20/8'h30/8'h40.
  - Write order is 10, 20, 30, 40, 10; grant_id sequence is 0, 1, 2, 3, 0.
- Busy poll: uart_rdata[1] = 1 for 3 polls, then 0.
  - Exactly 4 POLL cycles separated by 8-cycle gaps.
  - A single write follows; no write occurs while busy = 1 was sampled.
- Lock: req 2 with lock = 1 sends 3 bytes while req 0 and req 1 stay valid.
  - All 3 writes come from req 2.
  - After the lock drops, the next grant goes to req 3 if valid, else req 0.
- Reset mid-write: assert rst while uart_nwr = 0.
  - uart_nwr, uart_ncs and uart_nrd read 1 in the same cycle.
  - After release, FSM is in ARB, pointer = 0, req_ready = 0.
- Strobe check, run across all tests: the assertion (uart_nrd | uart_nwr) == 1 never fails, and uart_ncs = 1 whenever both uart_nrd and uart_nwr are high.
